// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single write port of an async FIFO between NUM_REQ requesters.
//   Lives entirely in the write clock domain, directly in front of the FIFO.
//   Grants rotate round-robin. Each grant lasts for at most MAX_BURST words.
//   The block never writes while the FIFO is full, and it counts the cycles in
//   which the granted requester is held off by full.
//
// Ports
//   wr_clk        in   write-domain clock (sole clock)
//   wr_rst        in   synchronous reset, active-high
//   req_valid     in   [NUM_REQ]            requester i has a word
//   req_data      in   [NUM_REQ*DATA_WIDTH] word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     out  [NUM_REQ]            word i accepted when valid & ready
//   fifo_full     in   FIFO full flag
//   fifo_wr_en    out  FIFO write enable
//   fifo_wr_data  out  [DATA_WIDTH]         FIFO write data
//   grant_id      out  [clog2(NUM_REQ)]     currently granted requester
//   busy          out  high while in GRANT (doubles as the FSM state view)
//   stall_cnt     out  [CNT_WIDTH]          saturating count of granted & valid & full cycles
//
// Handshake: a requester word moves on the cycle where req_valid[i] and
// req_ready[i] are both high. That same cycle, fifo_wr_en is high and
// fifo_wr_data carries the word. There is no skid buffer, so requester data is
// consumed only on that cycle.

module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          wr_clk,
   input  logic                          wr_rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy,
   output logic [CNT_WIDTH-1:0]          stall_cnt
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [GW-1:0] LAST_RST   = GW'(NUM_REQ - 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [GW-1:0]         r_grant_id, w_grant_nxt;
   logic [GW-1:0]         r_last_grant, w_last_nxt;
   logic [BW-1:0]         r_burst_cnt, w_burst_nxt;
   logic [CNT_WIDTH-1:0]  r_stall_cnt, w_stall_nxt;

   logic                  w_pick_found;
   logic [GW-1:0]         w_pick_idx;
   logic                  w_cur_valid;
   logic [DATA_WIDTH-1:0] w_cur_data;

   // Round-robin pick: the first valid requester after last_grant, with
   // wrap-around. The last granted requester is therefore scanned last.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!w_pick_found && req_valid[(int'(r_last_grant) + k) % NUM_REQ]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = GW'((int'(r_last_grant) + k) % NUM_REQ);
         end
      end
   end

   assign w_cur_valid  = req_valid[r_grant_id];
   assign w_cur_data   = req_data[int'(r_grant_id) * DATA_WIDTH +: DATA_WIDTH];
   assign fifo_wr_data = w_cur_data;
   assign grant_id     = r_grant_id;
   assign stall_cnt    = r_stall_cnt;

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant_id;
      w_last_nxt  = r_last_grant;
      w_burst_nxt = r_burst_cnt;
      w_stall_nxt = r_stall_cnt;
      req_ready   = '0;
      fifo_wr_en  = 1'b0;
      busy        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_pick_found) begin
               w_grant_nxt = w_pick_idx;
               w_burst_nxt = '0;
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            busy       = 1'b1;
            req_ready  = fifo_full ? '0 : (NUM_REQ'(1) << r_grant_id);
            fifo_wr_en = w_cur_valid & ~fifo_full;
            if (!w_cur_valid) begin
               // The requester ran dry, so release the grant early.
               w_last_nxt  = r_grant_id;
               w_state_nxt = ST_IDLE;
            end else if (fifo_full) begin
               // Hold the grant indefinitely. Only the stall counter moves.
               if (r_stall_cnt != '1) w_stall_nxt = r_stall_cnt + 1'b1;
            end else begin
               w_burst_nxt = r_burst_cnt + 1'b1;
               if (r_burst_cnt == BURST_LAST) begin
                  w_last_nxt  = r_grant_id;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // Outputs are gated during reset so that a mid-burst reset never writes.
      if (wr_rst) begin
         req_ready  = '0;
         fifo_wr_en = 1'b0;
         busy       = 1'b0;
      end
   end

   always_ff @(posedge wr_clk) begin
      if (wr_rst) begin
         r_state      <= ST_IDLE;
         r_grant_id   <= '0;
         r_last_grant <= LAST_RST;
         r_burst_cnt  <= '0;
         r_stall_cnt  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant_id   <= w_grant_nxt;
         r_last_grant <= w_last_nxt;
         r_burst_cnt  <= w_burst_nxt;
         r_stall_cnt  <= w_stall_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;
   localparam int CW = 16;
   localparam int GW = 2;

   // ---------------- clock / reset ----------------
   logic            wr_clk = 1'b0;
   logic            wr_rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            fifo_full = 1'b0;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_wr_data;
   logic [GW-1:0]   grant_id;
   logic            busy;
   logic [CW-1:0]   stall_cnt;

   always #5 wr_clk = ~wr_clk;

   fifo_wr_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)
   ) dut (
      .wr_clk(wr_clk), .wr_rst(wr_rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
      .grant_id(grant_id), .busy(busy), .stall_cnt(stall_cnt)
   );

   // ---------------- checking ----------------
   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Abstract view: who holds the grant, how many words were taken in it,
   // who was released last, and the totals per requester.
   bit  m_busy  = 0;
   int  m_grant = 0;
   int  m_last  = N - 1;
   int  m_burst = 0;
   int  m_stall = 0;
   int  m_words[N];
   int  dut_words[N];
   logic [DW-1:0] exp_q[$];
   int  dut_grants[$];
   bit  prev_busy = 0;
   logic [31:0] wr_hist = '0;

   // Requester i sends {i, sequence number}, so that word order is visible.
   function automatic logic [DW-1:0] word_of(input int i);
      return DW'((i << 5) | (m_words[i] & 31));
   endfunction

   // ---------------- driver: one clock cycle ----------------
   task automatic step(input bit rst, input logic [N-1:0] v, input bit full);
      logic [N-1:0] e_ready;
      bit           e_wr;
      wr_rst    = rst;
      req_valid = v;
      fifo_full = full;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = word_of(i);
      @(negedge wr_clk);

      e_ready = '0;
      e_wr    = 0;
      if (!rst && m_busy) begin
         if (!full) e_ready[m_grant] = 1'b1;
         e_wr = v[m_grant] && !full;
      end
      check("busy", 32'(busy), 32'(!rst && m_busy));
      check("grant_id", 32'(grant_id), 32'(m_grant));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("wr_en", 32'(fifo_wr_en), 32'(e_wr));
      check("wr_when_full", 32'(fifo_wr_en & fifo_full), 32'd0);

      // scoreboard
      if (e_wr) exp_q.push_back(word_of(m_grant));
      if (fifo_wr_en === 1'b1) begin
         if (exp_q.size() == 0) check("sb_extra", 32'd1, 32'd0);
         else check("sb_data", 32'(fifo_wr_data), 32'(exp_q.pop_front()));
      end
      for (int i = 0; i < N; i++)
         if (req_valid[i] && req_ready[i]) dut_words[i]++;
      if (busy === 1'b1 && !prev_busy) dut_grants.push_back(int'(grant_id));
      prev_busy = (busy === 1'b1);
      wr_hist   = {wr_hist[30:0], fifo_wr_en};

      // model advance (what the coming clock edge does)
      if (rst) begin
         m_busy = 0; m_grant = 0; m_last = N - 1; m_burst = 0; m_stall = 0;
      end else if (!m_busy) begin
         if (v != '0) begin
            for (int k = 1; k <= N; k++) begin
               if (v[(m_last + k) % N]) begin
                  m_grant = (m_last + k) % N;
                  break;
               end
            end
            m_burst = 0;
            m_busy  = 1;
         end
      end else if (!v[m_grant]) begin
         m_last = m_grant;
         m_busy = 0;
      end else if (full) begin
         if (m_stall < (1 << CW) - 1) m_stall++;
      end else begin
         m_words[m_grant]++;
         m_burst++;
         if (m_burst == MB) begin
            m_last = m_grant;
            m_busy = 0;
         end
      end
      @(posedge wr_clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base;
      int nfull;
      for (int i = 0; i < N; i++) begin
         m_words[i]   = 0;
         dut_words[i] = 0;
      end
      @(posedge wr_clk);
      #1;

      // 1: single requester, 6 words -> 4 writes, bubble, 2 writes, release
      step(1, '0, 0);
      step(1, '0, 0);
      wr_hist = '0;
      for (int c = 0; c < 9; c++) step(0, (m_words[0] < 6) ? 4'b0001 : 4'b0000, 0);
      check("t1_pattern", {23'd0, wr_hist[8:0]}, 32'b011110110);
      check("t1_words", 32'(dut_words[0]), 32'd6);

      // 2: all requesting -> grants 0,1,2,3,0
      step(1, '0, 0);
      dut_grants.delete();
      for (int c = 0; c < 24; c++) step(0, 4'b1111, 0);
      if (dut_grants.size() < 5) check("t2_ngrants", 32'(dut_grants.size()), 32'd5);
      else begin
         check("t2_g0", 32'(dut_grants[0]), 32'd0);
         check("t2_g1", 32'(dut_grants[1]), 32'd1);
         check("t2_g2", 32'(dut_grants[2]), 32'd2);
         check("t2_g3", 32'(dut_grants[3]), 32'd3);
         check("t2_g4", 32'(dut_grants[4]), 32'd0);
      end

      // 3: requester 1, full for 5 cycles after its 2nd word
      step(1, '0, 0);
      base  = dut_words[1];
      nfull = 0;
      for (int c = 0; c < 14; c++) begin
         bit f;
         f = m_busy && (m_words[1] - base == 2) && (nfull < 5);
         if (f) nfull++;
         step(0, (m_words[1] - base < 4) ? 4'b0010 : 4'b0000, f);
      end
      check("t3_stall", 32'(stall_cnt), 32'd5);
      check("t3_words", 32'(dut_words[1] - base), 32'd4);

      // 4: requester 2 drops after one word; requester 3 beats 0
      step(1, '0, 0);
      step(0, 4'b0100, 0);
      step(0, 4'b0100, 0);
      step(0, 4'b1001, 0);
      step(0, 4'b1001, 0);
      check("t4_grant", 32'(grant_id), 32'd3);
      check("t4_busy", 32'(busy), 32'd1);

      // 5: reset mid-burst of requester 3 (burst count 2, after a stall)
      step(0, 4'b1001, 1);
      step(0, 4'b1001, 0);
      step(0, 4'b1001, 0);
      step(1, 4'b1001, 0);
      step(0, 4'b1001, 0);
      check("t5_grant", 32'(grant_id), 32'd0);
      check("t5_stall", 32'(stall_cnt), 32'd0);

      // 6: random valid / full with rare resets
      for (int c = 0; c < 10000; c++)
         step(($urandom_range(0, 499) == 0), N'($urandom), ($urandom_range(0, 3) == 0));
      step(0, '0, 0);
      step(0, '0, 0);

      for (int i = 0; i < N; i++) check("words", 32'(dut_words[i]), 32'(m_words[i]));
      check("sb_left", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
